// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier. A single recoder/adder slice accumulates one
// partial product per clock; valid/ready handshakes on both operand and result sides.
module booth_r4_seq_mult #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   // state | meaning
   // IDLE  | waiting for an operand pair, in_ready high
   // CALC  | one Booth digit recoded and accumulated per clock
   // DONE  | product presented, held until out_ready

   localparam int EW = WIDTH + 2;
   localparam int N  = EW / 2;
   localparam int AW = 2 * EW;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [EW-1:0]   y_sh;
   logic            y_prev;
   logic [AW-1:0]   m_sh;
   logic [AW-1:0]   acc;
   logic [AW-1:0]   pp_mag;
   logic [AW-1:0]   pp_sel;
   logic [AW-1:0]   sum;
   logic            neg;
   logic [2:0]      triplet;
   logic            accept;
   logic            last_iter;

   assign accept    = in_valid & in_ready;
   assign last_iter = (cnt == CW'(N - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (last_iter) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // m_sh already carries the 2i weight, so the digit only selects M or 2M.
   assign triplet = {y_sh[1], y_sh[0], y_prev};

   always_comb begin
      pp_mag = '0;
      neg    = 1'b0;
      case (triplet)
         3'b001, 3'b010: pp_mag = m_sh;
         3'b011:         pp_mag = m_sh << 1;
         3'b100: begin
            pp_mag = m_sh << 1;
            neg    = 1'b1;
         end
         3'b101, 3'b110: begin
            pp_mag = m_sh;
            neg    = 1'b1;
         end
         default: begin
            pp_mag = '0;
            neg    = 1'b0;
         end
      endcase
   end

   // Negation as one's complement with the +1 folded in as the adder carry-in.
   assign pp_sel = neg ? ~pp_mag : pp_mag;
   assign sum    = acc + pp_sel + {{(AW-1){1'b0}}, neg};

   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         cnt    <= '0;
         m_sh   <= '0;
         y_sh   <= '0;
         y_prev <= 1'b0;
      end else if (accept) begin
         acc    <= '0;
         cnt    <= '0;
         y_prev <= 1'b0;
         if (is_signed) begin
            m_sh <= {{(AW-WIDTH){multiplicand[WIDTH-1]}}, multiplicand};
            y_sh <= {{(EW-WIDTH){multiplier[WIDTH-1]}}, multiplier};
         end else begin
            m_sh <= {{(AW-WIDTH){1'b0}}, multiplicand};
            y_sh <= {{(EW-WIDTH){1'b0}}, multiplier};
         end
      end else if (state == CALC) begin
         acc    <= sum;
         cnt    <= cnt + 1'b1;
         m_sh   <= m_sh << 2;
         y_sh   <= y_sh >> 2;
         y_prev <= y_sh[1];
      end
   end

   assign product = acc[2*WIDTH-1:0];

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Scoreboard bench for booth_r4_seq_mult: directed vectors with hand-computed products,
// backpressure, mid-operation reset, and a block of randomized pairs against a behavioural model.
module tb_booth_r4_seq_mult;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] multiplicand;
   logic [15:0] multiplier;
   logic        is_signed;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] product;
   logic        busy;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;
   logic        ready_rand = 1'b0;
   logic        ready_force = 1'b1;

   booth_r4_seq_mult #(.WIDTH(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .is_signed    (is_signed),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // out_ready driver: either a forced level or random stalls.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
      end
   end

   // Monitor: every accepted product is compared with the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", product, 32'hxxxx_xxxx);
            end else begin
               mon_exp = exp_q.pop_front();
               check("product", product, mon_exp);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic issue(input logic [15:0] m, input logic [15:0] y, input logic s,
                        input logic push, input logic [31:0] exp);
      int t;
      t = 0;
      while (!in_ready && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid     = 1'b1;
      multiplicand = m;
      multiplier   = y;
      is_signed    = s;
      if (push) exp_q.push_back(exp);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (!(in_ready && exp_q.size() == 0) && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 300) check("idle_timeout", {31'd0, in_ready}, 32'd1);
   endtask

   function automatic logic [31:0] model(input logic [15:0] m, input logic [15:0] y, input logic s);
      logic signed [31:0] ps;
      logic [31:0]        pu;
      ps = $signed(m) * $signed(y);
      pu = {16'd0, m} * {16'd0, y};
      return s ? ps : pu;
   endfunction

   typedef struct {
      logic [15:0] m;
      logic [15:0] y;
      logic        s;
      logic [31:0] p;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int cnt;
      logic [31:0] held;
      logic [15:0] rm, ry;
      logic        rs;

      rst = 1'b1;
      in_valid = 1'b0;
      multiplicand = '0;
      multiplier = '0;
      is_signed = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_in_ready",  {31'd0, in_ready},  32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_busy",      {31'd0, busy},      32'd0);
      check("reset_product",   product,            32'd0);

      // Most-negative squared, with exact latency measurement.
      issue(16'h8000, 16'h8000, 1'b1, 1'b1, 32'h4000_0000);
      check("busy_in_calc",     {31'd0, busy},     32'd1);
      check("in_ready_in_calc", {31'd0, in_ready}, 32'd0);
      cnt = 0;
      while (!out_valid && cnt < 40) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check("latency_edges", cnt, 32'd9);
      wait_idle();

      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001});
      vecs.push_back('{16'hFFFF, 16'h0001, 1'b1, 32'hFFFF_FFFF});
      vecs.push_back('{16'h0003, 16'hFFFE, 1'b1, 32'hFFFF_FFFA});
      vecs.push_back('{16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000});
      vecs.push_back('{16'h8000, 16'hFFFF, 1'b1, 32'h0000_8000});
      vecs.push_back('{16'h8000, 16'h8000, 1'b0, 32'h4000_0000});
      vecs.push_back('{16'h7FFF, 16'h0002, 1'b0, 32'h0000_FFFE});
      vecs.push_back('{16'h0000, 16'h1234, 1'b1, 32'h0000_0000});
      vecs.push_back('{16'd1234, 16'd5678, 1'b0, 32'd7006652});
      foreach (vecs[i]) issue(vecs[i].m, vecs[i].y, vecs[i].s, 1'b1, vecs[i].p);
      wait_idle();

      // Backpressure: result held, new operands ignored.
      ready_force = 1'b0;
      @(posedge clk);
      #1;
      issue(16'd1234, 16'd5678, 1'b0, 1'b1, 32'd7006652);
      cnt = 0;
      while (!out_valid && cnt < 40) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      held = product;
      check("bp_product_first", held, 32'd7006652);
      in_valid     = 1'b1;
      multiplicand = 16'h0011;
      multiplier   = 16'h0022;
      is_signed    = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_product",   product,            32'd7006652);
         check("bp_in_ready",  {31'd0, in_ready},  32'd0);
      end
      in_valid    = 1'b0;
      ready_force = 1'b1;
      @(posedge clk);
      #1;
      check("release_out_valid", {31'd0, out_valid}, 32'd0);
      check("release_in_ready",  {31'd0, in_ready},  32'd1);
      check("release_queue",     exp_q.size(),       32'd0);
      repeat (12) @(posedge clk);
      #1;
      check("no_ghost_op", {31'd0, busy}, 32'd0);

      // Reset during iteration 4 drops the operation.
      issue(16'h1234, 16'h4321, 1'b0, 1'b0, 32'd0);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midreset_in_ready",  {31'd0, in_ready},  32'd1);
      check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
      check("midreset_product",   product,            32'd0);
      issue(16'd7, 16'd6, 1'b0, 1'b1, 32'd42);
      wait_idle();

      // Randomized pairs with random output stalls.
      ready_rand = 1'b1;
      for (int k = 0; k < 1500; k++) begin
         rm = 16'($urandom);
         ry = 16'($urandom);
         rs = 1'($urandom_range(0, 1));
         if (k % 7 == 0) rm = 16'h8000;
         issue(rm, ry, rs, 1'b1, model(rm, ry, rs));
      end
      wait_idle();
      ready_rand = 1'b0;
      check("final_queue_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
